// File: rtl/dm_byteen_mem.sv
// Byte-enabled M-stage data memory: clear-on-reset sweep, address range check,
// read latency 0/1/2. Optional write-trace FIFO enabled by macro DM_TRACE_EN.
module dm_byteen_mem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        init_done,
  output logic        oob_err,
  output logic [31:0] oob_addr,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_ovf,
  output logic        dbg_state
);
  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_init_done;
  logic            r_oob_err;
  logic [31:0]     r_oob_addr;
  logic [31:0]     r_prev_addr;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [31:0]     w_off;
  logic            w_in_range;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_merged;
  logic            w_run;
  logic            w_access;
  logic            w_oob_evt;
  logic            w_bus_wr;
  logic [31:0]     w_rd_val;

  assign w_off      = m_data_addr - BASE_ADDR;
  assign w_in_range = {1'b0, w_off} < LIMIT;
  assign w_idx      = w_off[AW+1:2];
  assign w_run      = (r_state == ST_RUN);

  always_comb begin
    w_merged = r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) w_merged[8*i +: 8] = m_data_wdata[8*i +: 8];
    end
  end

  // A pure read only counts as an access when the address moves.
  assign w_access  = (|m_data_byteen) || (m_data_addr != r_prev_addr);
  assign w_oob_evt = w_run && !w_in_range && w_access;
  assign w_bus_wr  = w_run && w_in_range && (|m_data_byteen);
  assign w_rd_val  = (w_run && w_in_range) ? r_mem[w_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      if (!w_run) r_mem[r_cnt] <= 32'h0;
      else if (w_bus_wr) r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_oob_err   <= 1'b0;
      r_oob_addr  <= 32'h0;
      r_prev_addr <= 32'h0;
    end else begin
      r_prev_addr <= m_data_addr;
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(DEPTH_WORDS - 1)) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          if (w_oob_evt) begin
            r_oob_err <= 1'b1;
            if (!r_oob_err) r_oob_addr <= m_data_addr;
          end
        end
      endcase
    end
  end

  assign init_done = r_init_done;
  assign oob_err   = r_oob_err;
  assign oob_addr  = r_oob_addr;
  assign dbg_state = r_state;

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign m_data_rdata = w_rd_val;
    end else begin : g_latreg
      logic [31:0] r_rd1;
      // Write-first: same-cycle write returns the merged word.
      always_ff @(posedge clk) begin
        if (!reset) r_rd1 <= 32'h0;
        else        r_rd1 <= w_bus_wr ? w_merged : w_rd_val;
      end
      if (RD_LAT == 1) begin : g_lat1
        assign m_data_rdata = r_rd1;
      end else begin : g_lat2
        logic [31:0] r_rd2;
        always_ff @(posedge clk) begin
          if (!reset) r_rd2 <= 32'h0;
          else        r_rd2 <= r_rd1;
        end
        assign m_data_rdata = r_rd2;
      end
    end
  endgenerate

`ifdef DM_TRACE_EN
  localparam int unsigned PW = $clog2(TRACE_DEPTH);

  logic [95:0]   r_fifo [TRACE_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_ovf;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_full = (r_count == (PW+1)'(TRACE_DEPTH));
  assign w_pop  = (r_count != '0) && trace_ready;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign w_push = w_bus_wr && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset && w_push)
      r_fifo[r_wr_ptr] <= {m_inst_addr, m_data_addr[31:2], 2'b00, w_merged};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_bus_wr && w_full && !w_pop) r_ovf <= 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  assign trace_valid = (r_count != '0);
  assign trace_pc    = r_fifo[r_rd_ptr][95:64];
  assign trace_addr  = r_fifo[r_rd_ptr][63:32];
  assign trace_data  = r_fifo[r_rd_ptr][31:0];
  assign trace_ovf   = r_ovf;
`else
  logic w_unused_trace;
  assign w_unused_trace = &{1'b0, trace_ready, m_inst_addr};
  assign trace_valid = 1'b0;
  assign trace_pc    = 32'h0;
  assign trace_addr  = 32'h0;
  assign trace_data  = 32'h0;
  assign trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_dm_byteen_mem.sv
// Directed bench for dm_byteen_mem: three instances (RD_LAT 0/1/2, 16 words, base 0)
// share one bus; trace FIFO steps run only when DM_TRACE_EN is defined.
module tb_dm_byteen_mem;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] pc;
  logic        tready;

  logic [31:0] rdata [3];
  logic        done [3];
  logic        oerr [3];
  logic [31:0] oaddr [3];
  logic        tvalid [3];
  logic [31:0] tpc [3];
  logic [31:0] taddr [3];
  logic [31:0] tdata [3];
  logic        tovf [3];
  logic        dstate [3];

  int n_cmp = 0;
  int n_err = 0;
  int cycles;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dm_byteen_mem #(
      .DEPTH_WORDS(16), .BASE_ADDR(32'h0), .RD_LAT(g), .TRACE_DEPTH(4)
    ) u_dut (
      .clk(clk), .reset(reset),
      .m_data_addr(addr), .m_data_wdata(wdata), .m_data_byteen(be),
      .m_inst_addr(pc),
      .m_data_rdata(rdata[g]), .init_done(done[g]),
      .oob_err(oerr[g]), .oob_addr(oaddr[g]),
      .trace_valid(tvalid[g]), .trace_ready(tready),
      .trace_pc(tpc[g]), .trace_addr(taddr[g]), .trace_data(tdata[g]),
      .trace_ovf(tovf[g]), .dbg_state(dstate[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b;
    step();
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    while (!done[1] && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; pc = 32'h0; tready = 1'b0;
    step(); step();
    check("reset_init_done", 32'(done[1]), 32'h0);
    check("reset_oob_err", 32'(oerr[1]), 32'h0);
    check("reset_rdata", rdata[1], 32'h0);
    check("reset_state", 32'(dstate[1]), 32'h0);

    // Sweep: bus writes during INIT (one in range, one out of range) are ignored.
    reset = 1'b1;
    cycles = 0;
    while (!done[1] && cycles < 200) begin
      if (cycles == 9) begin addr = 32'h8; wdata = 32'hFFFF_FFFF; be = 4'hF; end
      else if (cycles == 10) begin addr = 32'h1000; wdata = 32'h1; be = 4'hF; end
      else begin addr = 32'h0; be = 4'h0; end
      step();
      cycles++;
      if (cycles == 5) begin
        check("init_read_lat1", rdata[1], 32'h0);
        check("init_read_lat0", rdata[0], 32'h0);
      end
    end
    check("init_cycles", 32'(cycles), 32'd16);
    check("init_done_lat0", 32'(done[0]), 32'h1);
    check("init_no_oob", 32'(oerr[1]), 32'h0);
    wr(32'h8, 32'h0, 4'h0);
    check("init_write_ignored", rdata[1], 32'h0);

    // Byte-lane merge.
    wr(32'h8, 32'hDEAD_BEEF, 4'hF);
    check("wr_full_first", rdata[1], 32'hDEAD_BEEF);
    wr(32'h8, 32'h0000_5500, 4'b0010);
    wr(32'h8, 32'h0, 4'h0);
    check("merge_lat1", rdata[1], 32'hDEAD_55EF);
    check("merge_lat0", rdata[0], 32'hDEAD_55EF);

    // Same-cycle write and read of word 1.
    addr = 32'h4; wdata = 32'h1234_5678; be = 4'hF;
    #1;
    check("lat0_old_value", rdata[0], 32'h0);
    step();
    check("lat1_write_first", rdata[1], 32'h1234_5678);
    check("lat0_next_cycle", rdata[0], 32'h1234_5678);
    wr(32'h4, 32'h0, 4'h0);
    check("lat2_delay", rdata[2], 32'h1234_5678);

    // Out-of-range writes: first address recorded, memory untouched.
    wr(32'h40, 32'hAAAA_AAAA, 4'hF);
    check("oob_set", 32'(oerr[1]), 32'h1);
    check("oob_addr_first", oaddr[1], 32'h40);
    wr(32'hFFFF_FFFC, 32'hBBBB_BBBB, 4'hF);
    check("oob_addr_kept", oaddr[1], 32'h40);
    check("oob_lat0_flag", 32'(oerr[0]), 32'h1);
    wr(32'h0, 32'h0, 4'h0);
    check("oob_word0_kept", rdata[1], 32'h0);
    wr(32'h3C, 32'h0, 4'h0);
    check("oob_word15_kept", rdata[1], 32'h0);
    wr(32'h80, 32'h0, 4'h0);
    check("oob_read_zero", rdata[1], 32'h0);

`ifndef DM_TRACE_EN
    check("trace_valid_tied", 32'(tvalid[1]), 32'h0);
    check("trace_ovf_tied", 32'(tovf[1]), 32'h0);
    check("trace_pc_tied", tpc[1], 32'h0);
    check("trace_data_tied", tdata[1], 32'h0);
`endif

    // Reset mid-sweep restarts the clear from word 0.
    addr = 32'h0; be = 4'h0;
    reset = 1'b0; step(); step();
    reset = 1'b1; step(); step(); step(); step(); step();
    reset = 1'b0; step();
    check("mid_reset_state", 32'(dstate[1]), 32'h0);
    reset = 1'b1;
    wait_init(cycles);
    check("restart_cycles", 32'(cycles), 32'd16);
    check("reset_clears_oob", 32'(oerr[1]), 32'h0);
    wr(32'h8, 32'h0, 4'h0);
    check("sweep_cleared", rdata[1], 32'h0);

    // Pure read that moves to an out-of-range address.
    wr(32'h44, 32'h0, 4'h0);
    check("read_oob_flag", 32'(oerr[1]), 32'h1);
    check("read_oob_addr", oaddr[1], 32'h44);

`ifdef DM_TRACE_EN
    reset = 1'b0; addr = 32'h0; step(); reset = 1'b1;
    wait_init(cycles);
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h3000 + 32'(4 * i);
      wr(32'h11 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    end
    be = 4'h0;
    check("trace_ovf_set", 32'(tovf[1]), 32'h1);
    check("trace_head_pc", tpc[1], 32'h3000);
    check("trace_head_addr", taddr[1], 32'h10);
    check("trace_head_data", tdata[1], 32'hA000_0000);
    tready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("trace_pop_pc", tpc[1], 32'h3000 + 32'(4 * i));
    end
    step();
    check("trace_empty", 32'(tvalid[1]), 32'h0);
    tready = 1'b0;

    reset = 1'b0; step(); reset = 1'b1;
    wait_init(cycles);
    check("trace_ovf_cleared", 32'(tovf[1]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      pc = 32'h4000 + 32'(4 * i);
      wr(32'h20, 32'(i), 4'hF);
    end
    pc = 32'h4010; tready = 1'b1;
    wr(32'h20, 32'h4, 4'hF);
    be = 4'h0; tready = 1'b0;
    check("full_pushpop_no_ovf", 32'(tovf[1]), 32'h0);
    check("full_pushpop_head", tpc[1], 32'h4004);
    tready = 1'b1;
    for (int i = 2; i < 5; i++) begin
      step();
      check("full_pushpop_pop", tpc[1], 32'h4000 + 32'(4 * i));
    end
    step();
    check("full_pushpop_empty", 32'(tvalid[1]), 32'h0);
    tready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
